// File: rtl/tt_factory_pkg.sv
// Shared definitions for the factory-test counter checker.
//   state_e          : checker FSM encoding (Idle/Sync/Lock; 2'b11 is unreachable)
//   SYNC_MATCHES     : consecutive +1 steps needed before locking
//   LOSS_MISMATCHES  : consecutive misses that drop lock (resync build only)
//   ERR_MAX          : saturation value of the error counter
package tt_factory_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StSync = 2'b01,
    StLock = 2'b10,
    StBad  = 2'b11
  } state_e;

  localparam int unsigned SYNC_MATCHES    = 4;
  localparam int unsigned LOSS_MISMATCHES = 4;
  localparam logic [7:0]  ERR_MAX         = 8'hFF;

  // Saturating increment for the error counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ERR_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/factory_rst_sync.sv
// Reset synchronizer: asserts asynchronously with rst_ni, deasserts on the first
// clock edge after rst_ni is released.
//   clk_i       : clock
//   rst_ni      : raw asynchronous active-low reset
//   rst_sync_no : synchronized active-low reset for the core logic
module factory_rst_sync (
  input  logic clk_i,
  input  logic rst_ni,
  output logic rst_sync_no
);

  logic rst_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rst_q <= 1'b0;
    end else begin
      rst_q <= 1'b1;
    end
  end

  assign rst_sync_no = rst_q;

endmodule

// File: rtl/tt_um_factory_checker.sv
// Factory-test counter checker. Locks onto an incrementing 8-bit stream on uio_in
// and counts deviations from it.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : always 1 when powered, ignored
//   ui_in      : [0] check enable, [1] clear errors, [2] display select
//   uio_in     : incoming counter stream
//   uo_out     : error count (ui_in[2]=0) or {lock, err_flag, state, 4'b0} (ui_in[2]=1)
//   uio_out    : constant 0
//   uio_oe     : constant 0, all uio pins are inputs
// Build option: define FACTORY_CHECKER_RESYNC_EN to drop lock back to SYNC after
// LOSS_MISMATCHES consecutive mismatches.
module tt_um_factory_checker
  import tt_factory_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [2:0] MatchLast = 3'(SYNC_MATCHES - 1);

  logic       rst_n_i;
  state_e     state_q;
  logic [7:0] in_q;
  logic [7:0] prev_q;
  logic [7:0] expected_q;
  logic [2:0] match_cnt_q;
  logic [7:0] err_cnt_q;
  logic       err_flag_q;
`ifdef FACTORY_CHECKER_RESYNC_EN
  localparam logic [2:0] MissLast = 3'(LOSS_MISMATCHES - 1);
  logic [2:0] miss_cnt_q;
`endif

  logic unused_in;
  assign unused_in = &{1'b0, ena, ui_in[7:3]};

  factory_rst_sync u_rst_sync (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rst_sync_no (rst_n_i)
  );

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      in_q        <= 8'h00;
      prev_q      <= 8'h00;
      expected_q  <= 8'h00;
      match_cnt_q <= 3'd0;
      err_cnt_q   <= 8'h00;
      err_flag_q  <= 1'b0;
`ifdef FACTORY_CHECKER_RESYNC_EN
      miss_cnt_q  <= 3'd0;
`endif
    end else begin
      in_q <= uio_in;
      if (!ui_in[0]) begin
        state_q <= StIdle;
`ifdef FACTORY_CHECKER_RESYNC_EN
        miss_cnt_q <= 3'd0;
`endif
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q     <= StSync;
            match_cnt_q <= 3'd0;
          end
          StSync: begin
            prev_q <= in_q;
            if (in_q == prev_q + 8'd1) begin
              if (match_cnt_q == MatchLast) begin
                state_q     <= StLock;
                expected_q  <= in_q + 8'd1;
                match_cnt_q <= 3'd0;
              end else begin
                match_cnt_q <= match_cnt_q + 3'd1;
              end
            end else begin
              match_cnt_q <= 3'd0;
            end
          end
          StLock: begin
            // Expected keeps free-running so a single glitch costs one error only.
            expected_q <= expected_q + 8'd1;
            if (in_q != expected_q) begin
              err_cnt_q  <= sat_inc(err_cnt_q);
              err_flag_q <= 1'b1;
`ifdef FACTORY_CHECKER_RESYNC_EN
              if (miss_cnt_q == MissLast) begin
                state_q     <= StSync;
                match_cnt_q <= 3'd0;
                miss_cnt_q  <= 3'd0;
              end else begin
                miss_cnt_q <= miss_cnt_q + 3'd1;
              end
            end else begin
              miss_cnt_q <= 3'd0;
`endif
            end
          end
          default: state_q <= StIdle;
        endcase
      end
      // Clear overrides any error update from the same cycle.
      if (ui_in[1]) begin
        err_cnt_q  <= 8'h00;
        err_flag_q <= 1'b0;
      end
    end
  end

  always_comb begin
    uo_out = err_cnt_q;
    if (ui_in[2]) begin
      uo_out = {(state_q == StLock), err_flag_q, state_q, 4'b0000};
    end
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: doc/tt_um_factory_checker.md
TT_UM_FACTORY_CHECKER -- requirements
Module: tt_um_factory_checker

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port ena, input, 1 bit: always 1 when powered; unused.
REQ-004 SHALL have port ui_in, input, 8 bits: [0] check enable, [1] clear errors, [2] display select, [7:3] unused.
REQ-005 SHALL have port uio_in, input, 8 bits: incoming counter stream from a factory-test generator.
REQ-006 SHALL have port uo_out, output, 8 bits: error count or status, per ui_in[2].
REQ-007 SHALL have port uio_out, output, 8 bits: constant 8'h00.
REQ-008 SHALL have port uio_oe, output, 8 bits: constant 8'h00, so all uio pins are inputs.

Function
REQ-009 SHALL register uio_in into in_q every cycle; all comparisons use in_q, giving 1-cycle input latency.
REQ-010 SHALL implement FSM with states IDLE=2'b00, SYNC=2'b01, LOCK=2'b10; code 2'b11 unreachable, recovers to IDLE.
REQ-011 IDLE: ui_in[0]=1 -> SYNC next cycle, match_cnt=0.
REQ-012 SYNC: each cycle prev<=in_q; if in_q==prev+1 mod 256 then match_cnt++, else match_cnt=0.
REQ-013 SYNC: on 4th consecutive match -> LOCK, expected<=in_q+1 mod 256.
REQ-014 LOCK: expected<=expected+1 mod 256 every cycle, independent of compare result.
REQ-015 LOCK: in_q!=expected -> err_cnt+1, saturating at 8'hFF, and sticky err_flag set.
REQ-016 Wrap 8'hFF->8'h00 SHALL count as a match in SYNC and LOCK.
REQ-017 ui_in[0]=0 in any state -> IDLE next cycle; err_cnt and err_flag hold.
REQ-018 ui_in[1]=1 -> err_cnt=0, err_flag=0 next edge; clear wins over a simultaneous mismatch.
REQ-019 uo_out: ui_in[2]=0 -> err_cnt; ui_in[2]=1 -> {lock, err_flag, state[1:0], 4'b0000}; lock = (state==LOCK).
REQ-020 uo_out SHALL be combinational from registered state and ui_in[2] only.

Reset
REQ-021 SHALL derive rst_n_i from one flop: cleared asynchronously by rst_n low, set to 1 on first clk edge after rst_n high.
REQ-022 All other flops SHALL be async-cleared by rst_n_i: state=IDLE, in_q, prev, expected, match_cnt, miss_cnt, err_cnt=0, err_flag=0.
REQ-023 uo_out SHALL read 8'h00 throughout reset and until the first post-reset update; uio_out and uio_oe stay 8'h00.
REQ-024 Reset mid-LOCK SHALL discard lock and counts; no history survives.

Configuration
REQ-025 Macro FACTORY_CHECKER_RESYNC_EN defined: LOCK counts consecutive mismatches in miss_cnt (cleared on match); the 4th consecutive mismatch -> SYNC with match_cnt=0; errors still counted.
REQ-026 FACTORY_CHECKER_RESYNC_EN undefined: no miss_cnt; LOCK exits only via ui_in[0]=0 or reset.

Structure
REQ-027 Shared package tt_factory_pkg SHALL hold the state encodings, SYNC_MATCHES=4, LOSS_MISMATCHES=4 and ERR_MAX=8'hFF.
REQ-028 Reset synchronizer (REQ-021) SHALL be sub-module factory_rst_sync; the remaining logic is flat.

Verification
REQ-029 ui_in=8'h05, uio_in counting 0x10,0x11,... -> status uo_out=8'hA0 (LOCK, no error) within 6 cycles of enable.
REQ-030 Locked; inject uio_in 0x55 once, then resume sequence -> err_cnt=1, err_flag=1, state stays LOCK.
REQ-031 Locked across 0xFE,0xFF,0x00,0x01 -> err_cnt stays 0.
REQ-032 Force 300 mismatches -> err_cnt=8'hFF; then ui_in[1]=1 for one cycle -> err_cnt=0, err_flag=0.
REQ-033 With FACTORY_CHECKER_RESYNC_EN, stuck uio_in=8'h00 in LOCK -> SYNC after 4 cycles; counting restarts -> LOCK again. Without the macro -> remains LOCK.
REQ-034 rst_n low mid-LOCK -> uo_out=8'h00, state IDLE; after release uio_oe=uio_out=8'h00.
